// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the RAM port-A arbiter.
// Owner tags, issue-state constants and default AW/DW.
package mem_arb_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_IO   = 2'd2
    } owner_e;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE_CPU = 2'd1;
    localparam logic [1:0] ST_ISSUE_IO  = 2'd2;

endpackage

// File: rtl/mem_port_arb_pick.sv
// Eligibility mask and winner select for the RAM port arbiter.
// MEM_ARB_STARVE_GUARD_EN adds a forced IO win once io_wait reaches LIMIT.
module arb_pick
    import mem_arb_pkg::*;
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
    parameter logic [3:0] LIMIT = 4'd4
)
`endif
(
    input  logic       i_cpu_req,
    input  logic       i_io_req,
    input  logic       i_cpu_gnt,
    input  logic       i_io_gnt,
`ifdef MEM_ARB_STARVE_GUARD_EN
    input  logic [3:0] i_io_wait,
`endif
    output owner_e     o_win
);

    logic w_cpu_elig;
    logic w_io_elig;
    logic w_io_force;

    // A requester granted this cycle sits out one cycle.
    assign w_cpu_elig = i_cpu_req & ~i_cpu_gnt;
    assign w_io_elig  = i_io_req & ~i_io_gnt;

`ifdef MEM_ARB_STARVE_GUARD_EN
    assign w_io_force = w_io_elig & (i_io_wait >= LIMIT);
`else
    assign w_io_force = 1'b0;
`endif

    always_comb begin
        o_win = OWN_NONE;
        if (w_io_force)
            o_win = OWN_IO;
        else if (w_cpu_elig)
            o_win = OWN_CPU;
        else if (w_io_elig)
            o_win = OWN_IO;
    end

endmodule

// File: rtl/mem_port_arb.sv
// RAM port-A arbiter: CPU has fixed priority over the IO master.
// Define MEM_ARB_STARVE_GUARD_EN to enable the IO starvation guard.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic          io_rvalid,
    output logic [DW-1:0] io_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..15");
    end

    owner_e        w_win;
    logic [1:0]    r_state;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_rd_tag;
    logic [DW-1:0] r_cpu_hold;
    logic [DW-1:0] r_io_hold;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] r_io_wait;

    arb_pick #(
        .LIMIT (4'(MAX_WAIT))
    ) u_pick (
        .i_cpu_req (cpu_req),
        .i_io_req  (io_req),
        .i_cpu_gnt (cpu_gnt),
        .i_io_gnt  (io_gnt),
        .i_io_wait (r_io_wait),
        .o_win     (w_win)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_io_wait <= 4'd0;
        else if (io_gnt)
            r_io_wait <= 4'd0;
        else if (io_req && w_win != OWN_IO && r_io_wait != 4'd15)
            r_io_wait <= r_io_wait + 4'd1;
    end
`else
    arb_pick u_pick (
        .i_cpu_req (cpu_req),
        .i_io_req  (io_req),
        .i_cpu_gnt (cpu_gnt),
        .i_io_gnt  (io_gnt),
        .o_win     (w_win)
    );
`endif

    // Address and write data hold their last values while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            unique case (w_win)
                OWN_CPU: begin
                    r_state <= ST_ISSUE_CPU;
                    r_we    <= cpu_we;
                    r_addr  <= cpu_addr;
                    r_wdata <= cpu_wdata;
                end
                OWN_IO: begin
                    r_state <= ST_ISSUE_IO;
                    r_we    <= io_we;
                    r_addr  <= io_addr;
                    r_wdata <= io_wdata;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_gnt   = (r_state == ST_ISSUE_CPU);
    assign io_gnt    = (r_state == ST_ISSUE_IO);
    assign ram_en    = cpu_gnt | io_gnt;
    assign ram_we    = r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

    // Tag is {valid, is_io} for the read issued one cycle earlier.
    always_ff @(posedge clk) begin
        if (reset)
            r_rd_tag <= 2'b00;
        else
            r_rd_tag <= {ram_en & ~r_we, io_gnt};
    end

    assign cpu_rvalid = r_rd_tag[1] & ~r_rd_tag[0];
    assign io_rvalid  = r_rd_tag[1] & r_rd_tag[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_hold <= '0;
            r_io_hold  <= '0;
        end else begin
            if (cpu_rvalid)
                r_cpu_hold <= ram_rdata;
            if (io_rvalid)
                r_io_hold <= ram_rdata;
        end
    end

    assign cpu_rdata = cpu_rvalid ? ram_rdata : r_cpu_hold;
    assign io_rdata  = io_rvalid ? ram_rdata : r_io_hold;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb with a 1-cycle RAM model.
// Starvation checks follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        io_req, io_we;
    logic [15:0] io_addr, io_wdata;
    logic        io_gnt, io_rvalid;
    logic [15:0] io_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata;
    logic [15:0] ram_rdata = 16'h0;
    logic [15:0] mem [0:255];

    int n_chk = 0;
    int n_err = 0;

    mem_port_arb #(.AW(16), .DW(16), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .io_req     (io_req),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_gnt     (io_gnt),
        .io_rvalid  (io_rvalid),
        .io_rdata   (io_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                mem[ram_addr[7:0]] <= ram_wdata;
            else
                ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pulses();
        return {ram_en, ram_we, cpu_gnt, io_gnt, cpu_rvalid, io_rvalid};
    endfunction

    initial begin
        int first_io;
        int cpu_cnt;
        int io_cnt;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h10] = 16'hBEEF;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        io_req = 0; io_we = 0; io_addr = 0; io_wdata = 0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_pulses", 32'(pulses()), 32'h0);
        check("rst_addr", 32'(ram_addr), 32'h0);
        check("rst_rdata", {cpu_rdata, io_rdata}, 32'h0);

        // CPU read only
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        tick();
        check("rd_gnt", 32'({cpu_gnt, io_gnt, ram_en}), 32'b101);
        check("rd_addr", 32'(ram_addr), 32'h0010);
        cpu_req = 0;
        tick();
        check("rd_rvalid", 32'({cpu_rvalid, io_rvalid}), 32'b10);
        check("rd_data", 32'(cpu_rdata), 32'hBEEF);

        // Simultaneous CPU write / IO read
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
        io_req = 1; io_we = 0; io_addr = 16'h0020;
        tick();
        check("sim_c1", 32'({cpu_gnt, io_gnt, ram_we}), 32'b101);
        cpu_req = 0;
        tick();
        check("sim_c2", 32'({cpu_gnt, io_gnt, ram_we, cpu_rvalid}), 32'b0100);
        check("sim_c2_addr", 32'(ram_addr), 32'h0020);
        io_req = 0;
        tick();
        check("sim_c3_rv", 32'({io_rvalid, cpu_rvalid}), 32'b10);
        check("sim_c3_data", 32'(io_rdata), 32'h1234);
        check("sim_cpu_hold", 32'(cpu_rdata), 32'hBEEF);

        // Self-mask: held request
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        tick();
        check("mask_c1", 32'(cpu_gnt), 32'h1);
        tick();
        check("mask_c2", 32'({cpu_gnt, cpu_rvalid}), 32'b01);
        tick();
        check("mask_c3", 32'(cpu_gnt), 32'h1);
        cpu_req = 0;
        tick();
        check("mask_c4", 32'({cpu_gnt, cpu_rvalid}), 32'b01);
        check("mask_c4_data", 32'(cpu_rdata), 32'hBEEF);

        // Reset during an IO read
        io_req = 1; io_we = 0; io_addr = 16'h0010;
        tick();
        check("rrd_gnt", 32'(io_gnt), 32'h1);
        io_req = 0;
        reset = 1;
        tick();
        reset = 0;
        check("rrd_pulses", 32'(pulses()), 32'h0);
        check("rrd_addr", 32'(ram_addr), 32'h0);
        check("rrd_rdata", {cpu_rdata, io_rdata}, 32'h0);

        // Write then idle
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
        tick();
        check("idle_wr", 32'({cpu_gnt, ram_we}), 32'b11);
        cpu_req = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("idle_p%0d", k), 32'(pulses()), 32'h0);
            check($sformatf("idle_a%0d", k), 32'(ram_addr), 32'h0030);
        end
        check("idle_mem", 32'(mem[8'h30]), 32'h5555);

        // IO only eligible while CPU is eligible
        first_io = -1;
        cpu_cnt = 0;
        io_cnt = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        io_we = 0; io_addr = 16'h0040;
        for (int k = 0; k < 20; k++) begin
            io_req = (k % 2 == 0);
            tick();
            if (io_gnt) begin
                io_cnt++;
                if (first_io < 0) first_io = k + 1;
            end
            if (cpu_gnt && first_io < 0) cpu_cnt++;
        end
        cpu_req = 0;
        io_req = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        check("guard_first_io", 32'(first_io), 32'd9);
        check("guard_cpu_wins", 32'(cpu_cnt), 32'd4);
`else
        check("strict_io_cnt", 32'(io_cnt), 32'd0);
        check("strict_cpu_cnt", 32'(cpu_cnt), 32'd10);
`endif
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbitrates single RAM port A between two requesters: the CPU control FSM (fetch/load/store) and an IO master (e.g. display/DMA engine).
- Sits between the control FSM / LS-counter mux and the block RAM.
- Issues at most one access per cycle, returns read data tagged to the winning requester.
- Fixed CPU priority, with an optional starvation guard for IO.

Parameters:
- AW, 16, RAM address width
- DW, 16, data width
- MAX_WAIT, 4, IO wait cycles before forced IO grant (guard feature only); legal range 1..15

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held with fields stable until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU access presented to RAM this cycle
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DW  read data to CPU
- io_req, io_we, io_addr, io_wdata  in  1/1/AW/DW  IO request bundle, same rules as CPU
- io_gnt, io_rvalid  out  1  IO grant / read-valid pulses
- io_rdata  out  DW  read data to IO
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, 1-cycle latency after ram_en

Behaviour:
- Reset: all outputs 0; owner = NONE; rd pipeline cleared; wait counter 0.
  - Read in flight at reset is dropped; no rvalid is issued afterwards.
- Arbitration (cycle N, combinational on sampled reqs):
  - Eligible = req high AND not granted in cycle N.
  - Winner = CPU if eligible; else IO if eligible; else none.
- Registered issue in cycle N+1:
  - ram_en=1; ram_we/addr/wdata copied from winner.
  - Winner's gnt=1; other gnt=0.
  - No winner -> ram_en=0, ram_we=0; addr/wdata hold their previous values.
- Read return: if issue in N+1 was a read, then in cycle N+2:
  - Owner's rvalid=1; owner's rdata=ram_rdata (registered capture not required; pass-through mux plus registered owner tag).
  - Writes produce no rvalid.
- Latency: req→gnt 1 cycle; req→rvalid 2 cycles.
- Throughput:
  - Same requester: max one access per 2 cycles (self-mask).
  - Alternating CPU/IO: back-to-back every cycle.
- rdata outputs hold their last value when rvalid=0.
- Simultaneous req with no guard: CPU always wins; IO waits indefinitely if CPU is eligible every cycle.
- Internal states:
  - IDLE (no issue)
  - ISSUE_CPU
  - ISSUE_IO
  - Next state = winner of the current cycle.
- Separate 2-bit read-tag pipe {valid, owner}.
- Requester deasserting req before gnt: request cancelled, no access made.

Optional Feature:
- Macro MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - 4-bit io_wait counter increments each cycle io_req is eligible but loses; saturates at 15.
  - When io_wait ≥ MAX_WAIT and IO is eligible, IO wins over CPU.
  - Counter clears on io_gnt or reset.
- Undefined: strict CPU priority; counter absent.

Decomposition:
- Shared package mem_arb_pkg:
  - owner encoding: NONE=2'd0, CPU=2'd1, IO=2'd2
  - state encoding for IDLE/ISSUE_CPU/ISSUE_IO
  - default AW/DW constants
- One natural sub-module: arb_pick (combinational eligibility mask plus priority/guard select).
- Issue registers and read-tag pipe stay in the top module.

Test Plan:
- CPU read only:
  - Stimulus: cpu_req=1, we=0, addr=0x0010 at cycle 0; RAM holds 0xBEEF.
  - Response: cycle 1 cpu_gnt=1, ram_en=1, ram_addr=0x0010; cycle 2 cpu_rvalid=1, cpu_rdata=0xBEEF; io_* pulses stay 0.
- Simultaneous requests:
  - Stimulus: CPU write 0x0020←0x1234 and IO read 0x0020, both at cycle 0.
  - Response: cycle 1 cpu_gnt, ram_we=1; cycle 2 io_gnt; cycle 3 io_rvalid=1, io_rdata=0x1234.
- Self-mask:
  - Stimulus: cpu_req held high 4 cycles.
  - Response: cpu_gnt pulses in cycles 1 and 3 only, never two consecutive cycles.
- Reset mid-read:
  - Stimulus: IO read granted in cycle 1; reset=1 in cycle 1.
  - Response: cycle 2 io_rvalid=0, all outputs 0.
- Starvation guard (macro defined, MAX_WAIT=4):
  - Stimulus: CPU and IO requests toggled so both are eligible every cycle.
  - Response: IO granted after ≤4 consecutive CPU wins, then io_wait=0.
  - With the macro undefined, the same stimulus yields no io_gnt within 20 cycles.
- Idle:
  - Stimulus: no requests for 5 cycles after a write to 0x0030.
  - Response: ram_en=0, ram_we=0, ram_addr holds 0x0030, no gnt or rvalid pulses.
